// File: rtl/spike_rate_decoder_pkg.sv
// Shared constants and FSM encoding for the spike rate decoder.
// Neuron count and frame length match the upstream Hopfield network.
package spike_rate_decoder_pkg;

   localparam int N_NEURONS  = 7;
   localparam int FRAME_CLKS = 7;
   localparam int IDX_W      = 3;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_SCAN    = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Spike input and decision-result bundle for the spike rate decoder.
interface spike_rate_decoder_if #(
   parameter int N     = 7,
   parameter int CNT_W = 5
);

   logic             enable;
   logic [N-1:0]     spikes_in;
   logic             result_valid;
   logic [2:0]       winner_idx;
   logic [CNT_W-1:0] winner_count;
   logic [N-1:0]     pattern_out;
   logic             no_activity;
   logic             busy;

   modport master (
      output enable,
      output spikes_in,
      input  result_valid,
      input  winner_idx,
      input  winner_count,
      input  pattern_out,
      input  no_activity,
      input  busy
   );

   modport slave (
      input  enable,
      input  spikes_in,
      output result_valid,
      output winner_idx,
      output winner_count,
      output pattern_out,
      output no_activity,
      output busy
   );

endinterface

// File: rtl/spike_rate_decoder_counter_bank.sv
// N saturating per-neuron spike counters with a shadow snapshot.
// Snapshot captures the count including the increment of the same edge.
module spike_counter_bank #(
   parameter int N     = 7,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N-1:0]       inc,
   input  logic               clear,
   input  logic               snap,
   output logic [N*CNT_W-1:0] live_flat,
   output logic [N*CNT_W-1:0] shadow_flat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   for (genvar g = 0; g < N; g++) begin : g_cnt
      logic [CNT_W-1:0] r_live;
      logic [CNT_W-1:0] r_shadow;
      logic [CNT_W-1:0] w_next;

      assign w_next = (r_live == CNT_MAX) ? CNT_MAX
                    : r_live + CNT_W'(inc[g]);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_live   <= '0;
            r_shadow <= '0;
         end else begin
            if (snap) r_shadow <= w_next;
            if (clear || snap) r_live <= '0;
            else               r_live <= w_next;
         end
      end

      assign live_flat[g*CNT_W +: CNT_W]   = r_live;
      assign shadow_flat[g*CNT_W +: CNT_W] = r_shadow;
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts spikes per frame over a window,
// then scans the snapshot serially for the most active neuron.
module spike_rate_decoder
   import spike_rate_decoder_pkg::*;
#(
   parameter int N         = N_NEURONS,
   parameter int FRAME_LEN = FRAME_CLKS,
   parameter int WINDOW    = 16,
   parameter int CNT_W     = 5,
   parameter int THRESH    = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   spike_rate_decoder_if.slave   bus
);

   localparam int PH_W = $clog2(FRAME_LEN + 1);
   localparam int FR_W = $clog2(WINDOW + 1);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(FRAME_LEN - 1);
   localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
   localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);

   if (WINDOW * FRAME_LEN <= N + 2) begin : g_bad_window
      $error("WINDOW*FRAME_LEN must exceed N+2");
   end
   if (N > 8) begin : g_bad_n
      $error("N must not exceed 8");
   end

   logic [PH_W-1:0]    r_phase;
   logic [FR_W-1:0]    r_frame;
   state_t             r_state;
   state_t             w_state_nx;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   r_best_idx;
   logic [CNT_W-1:0]   r_best_cnt;

   logic               r_valid;
   logic [IDX_W-1:0]   r_win_idx;
   logic [CNT_W-1:0]   r_win_cnt;
   logic [N-1:0]       r_pattern;
   logic               r_no_act;

   logic               w_strobe;
   logic               w_sample;
   logic               w_win_end;
   logic [N-1:0]       w_inc;
   logic [N*CNT_W-1:0] w_live;
   logic [N*CNT_W-1:0] w_shadow;
   logic [CNT_W-1:0]   w_cur;
   logic [N-1:0]       w_pattern;

   assign w_strobe  = (r_phase == PH_LAST);
   assign w_sample  = w_strobe && bus.enable;
   assign w_win_end = w_sample && (r_frame == FR_LAST);
   assign w_inc     = bus.spikes_in & {N{w_sample}};

   spike_counter_bank #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_bank (
      .clk         (clk),
      .reset_n     (reset_n),
      .inc         (w_inc),
      .clear       (~bus.enable),
      .snap        (w_win_end),
      .live_flat   (w_live),
      .shadow_flat (w_shadow)
   );

   assign w_cur = w_shadow[int'(r_idx)*CNT_W +: CNT_W];

   always_comb begin
      w_pattern = '0;
      for (int i = 0; i < N; i++) begin
         w_pattern[i] = (w_shadow[i*CNT_W +: CNT_W] >= THR);
      end
   end

   // Phase free-runs so frame alignment with the upstream scan survives enable toggles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= '0;
      end else if (w_strobe) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame <= '0;
      end else if (!bus.enable) begin
         r_frame <= '0;
      end else if (w_sample) begin
         r_frame <= w_win_end ? '0 : r_frame + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_ACCUM;
      else          r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_ACCUM:   if (w_win_end) w_state_nx = ST_SCAN;
         ST_SCAN:    if (r_idx == IDX_LAST) w_state_nx = ST_PUBLISH;
         ST_PUBLISH: w_state_nx = ST_ACCUM;
         default:    w_state_nx = ST_ACCUM;
      endcase
   end

   // Strict compare keeps the lowest index on ties
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx      <= '0;
         r_best_idx <= '0;
         r_best_cnt <= '0;
      end else if (w_win_end) begin
         r_idx      <= '0;
         r_best_idx <= '0;
         r_best_cnt <= '0;
      end else if (r_state == ST_SCAN) begin
         r_idx <= r_idx + 1'b1;
         if (w_cur > r_best_cnt) begin
            r_best_cnt <= w_cur;
            r_best_idx <= r_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid   <= 1'b0;
         r_win_idx <= '0;
         r_win_cnt <= '0;
         r_pattern <= '0;
         r_no_act  <= 1'b0;
      end else begin
         r_valid <= (r_state == ST_PUBLISH);
         if (r_state == ST_PUBLISH) begin
            r_win_idx <= r_best_idx;
            r_win_cnt <= r_best_cnt;
            r_pattern <= w_pattern;
            r_no_act  <= (r_best_cnt == '0);
         end
      end
   end

   assign bus.result_valid = r_valid;
   assign bus.winner_idx   = r_win_idx;
   assign bus.winner_count = r_win_cnt;
   assign bus.pattern_out  = r_pattern;
   assign bus.no_activity  = r_no_act;
   assign bus.busy         = (r_state != ST_ACCUM);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed testbench for spike_rate_decoder: default and override instances.
module tb_spike_rate_decoder;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   edge_cnt = 0;
   int   rel = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   spike_rate_decoder_if #(.N(7), .CNT_W(5)) ifa ();
   spike_rate_decoder_if #(.N(7), .CNT_W(4)) ifb ();

   spike_rate_decoder dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifa)
   );

   spike_rate_decoder #(
      .CNT_W  (4),
      .WINDOW (20)
   ) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifb)
   );

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      rel = edge_cnt;
   endtask

   // Returns edge index (relative to reset release) after which result_valid rose, or -1
   task automatic wait_valid(input bit sel_b, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if ((sel_b ? ifb.result_valid : ifa.result_valid) === 1'b1) begin
            at = edge_cnt - rel;
            return;
         end
      end
   endtask

   task automatic test_reset();
      ifa.enable = 1'b0; ifa.spikes_in = '0;
      ifb.enable = 1'b0; ifb.spikes_in = '0;
      repeat (2) @(negedge clk);
      checks++; if (ifa.result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ifa.result_valid); end
      checks++; if (ifa.winner_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", ifa.winner_idx); end
      checks++; if (ifa.winner_count !== 5'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", ifa.winner_count); end
      checks++; if (ifa.pattern_out !== 7'd0) begin errors++; $display("FAIL rst_pat: got %b want 0", ifa.pattern_out); end
      checks++; if (ifa.no_activity !== 1'b0) begin errors++; $display("FAIL rst_noact: got %b want 0", ifa.no_activity); end
      checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
   endtask

   task automatic test_basic();
      int at;
      ifa.enable = 1'b1; ifa.spikes_in = 7'b0000101;
      do_reset();
      wait_valid(1'b0, 200, at);
      checks++; if (at !== 120) begin errors++; $display("FAIL basic_latency: got %0d want 120", at); end
      checks++; if (ifa.winner_idx !== 3'd0) begin errors++; $display("FAIL basic_idx: got %0d want 0", ifa.winner_idx); end
      checks++; if (ifa.winner_count !== 5'd16) begin errors++; $display("FAIL basic_cnt: got %0d want 16", ifa.winner_count); end
      checks++; if (ifa.pattern_out !== 7'b0000101) begin errors++; $display("FAIL basic_pat: got %b want 0000101", ifa.pattern_out); end
      checks++; if (ifa.no_activity !== 1'b0) begin errors++; $display("FAIL basic_noact: got %b want 0", ifa.no_activity); end
      @(negedge clk);
      checks++; if (ifa.result_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", ifa.result_valid); end
      checks++; if (ifa.winner_count !== 5'd16) begin errors++; $display("FAIL basic_hold: got %0d want 16", ifa.winner_count); end
   endtask

   task automatic test_back_to_back();
      int at;
      // Continues from test_basic: second window follows with no gap
      wait_valid(1'b0, 200, at);
      checks++; if (at !== 232) begin errors++; $display("FAIL b2b_latency: got %0d want 232", at); end
      checks++; if (ifa.winner_count !== 5'd16) begin errors++; $display("FAIL b2b_cnt: got %0d want 16", ifa.winner_count); end
   endtask

   task automatic test_tie();
      int at;
      ifa.enable = 1'b1; ifa.spikes_in = 7'b0101000;
      do_reset();
      repeat (70) @(negedge clk);
      ifa.spikes_in = 7'b0000000;
      wait_valid(1'b0, 200, at);
      checks++; if (at !== 120) begin errors++; $display("FAIL tie_latency: got %0d want 120", at); end
      checks++; if (ifa.winner_idx !== 3'd3) begin errors++; $display("FAIL tie_idx: got %0d want 3", ifa.winner_idx); end
      checks++; if (ifa.winner_count !== 5'd10) begin errors++; $display("FAIL tie_cnt: got %0d want 10", ifa.winner_count); end
      checks++; if (ifa.pattern_out !== 7'b0101000) begin errors++; $display("FAIL tie_pat: got %b want 0101000", ifa.pattern_out); end
   endtask

   task automatic test_zero();
      int at;
      ifa.enable = 1'b1; ifa.spikes_in = 7'b0000000;
      do_reset();
      wait_valid(1'b0, 200, at);
      checks++; if (at !== 120) begin errors++; $display("FAIL zero_latency: got %0d want 120", at); end
      checks++; if (ifa.no_activity !== 1'b1) begin errors++; $display("FAIL zero_noact: got %b want 1", ifa.no_activity); end
      checks++; if (ifa.winner_idx !== 3'd0) begin errors++; $display("FAIL zero_idx: got %0d want 0", ifa.winner_idx); end
      checks++; if (ifa.winner_count !== 5'd0) begin errors++; $display("FAIL zero_cnt: got %0d want 0", ifa.winner_count); end
      checks++; if (ifa.pattern_out !== 7'd0) begin errors++; $display("FAIL zero_pat: got %b want 0", ifa.pattern_out); end
   endtask

   task automatic test_enable_drop();
      int at;
      ifa.enable = 1'b1; ifa.spikes_in = 7'b1000000;
      do_reset();
      repeat (56) @(negedge clk);
      ifa.enable = 1'b0;
      repeat (21) @(negedge clk);
      ifa.enable = 1'b1;
      wait_valid(1'b0, 300, at);
      checks++; if (at !== 197) begin errors++; $display("FAIL drop_latency: got %0d want 197", at); end
      checks++; if (ifa.winner_idx !== 3'd6) begin errors++; $display("FAIL drop_idx: got %0d want 6", ifa.winner_idx); end
      checks++; if (ifa.winner_count !== 5'd16) begin errors++; $display("FAIL drop_cnt: got %0d want 16", ifa.winner_count); end
   endtask

   task automatic test_saturate();
      int at;
      ifa.enable = 1'b0;
      ifb.enable = 1'b1; ifb.spikes_in = 7'b0000010;
      do_reset();
      wait_valid(1'b1, 250, at);
      checks++; if (at !== 148) begin errors++; $display("FAIL sat_latency: got %0d want 148", at); end
      checks++; if (ifb.winner_idx !== 3'd1) begin errors++; $display("FAIL sat_idx: got %0d want 1", ifb.winner_idx); end
      checks++; if (ifb.winner_count !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", ifb.winner_count); end
      checks++; if (ifb.pattern_out !== 7'b0000010) begin errors++; $display("FAIL sat_pat: got %b want 0000010", ifb.pattern_out); end
      ifb.enable = 1'b0;
   endtask

   task automatic test_reset_in_scan();
      int at;
      int seen;
      ifa.enable = 1'b1; ifa.spikes_in = 7'b0000101;
      do_reset();
      wait_valid(1'b0, 200, at);
      checks++; if (at !== 120) begin errors++; $display("FAIL rscan_first: got %0d want 120", at); end
      repeat (107) @(negedge clk);
      checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL rscan_busy: got %b want 1", ifa.busy); end
      reset_n = 1'b0;
      #1;
      checks++; if (ifa.winner_count !== 5'd0) begin errors++; $display("FAIL rscan_cnt: got %0d want 0", ifa.winner_count); end
      checks++; if (ifa.pattern_out !== 7'd0) begin errors++; $display("FAIL rscan_pat: got %b want 0", ifa.pattern_out); end
      checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rscan_busy0: got %b want 0", ifa.busy); end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (ifa.result_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rscan_novalid: got %0d want 0", seen); end
      ifa.spikes_in = 7'b0010000;
      reset_n = 1'b1;
      rel = edge_cnt;
      wait_valid(1'b0, 200, at);
      checks++; if (at !== 120) begin errors++; $display("FAIL rscan_latency: got %0d want 120", at); end
      checks++; if (ifa.winner_idx !== 3'd4) begin errors++; $display("FAIL rscan_idx: got %0d want 4", ifa.winner_idx); end
      checks++; if (ifa.winner_count !== 5'd16) begin errors++; $display("FAIL rscan_cnt2: got %0d want 16", ifa.winner_count); end
      checks++; if (ifa.pattern_out !== 7'b0010000) begin errors++; $display("FAIL rscan_pat2: got %b want 0010000", ifa.pattern_out); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_tie();
      test_zero();
      test_enable_drop();
      test_saturate();
      test_reset_in_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
